// File: rtl/audio_sample_fifo_if.sv
// Host/transceiver-side bundle for the audio sample FIFO: playback push, DAC
// request/sample, ADC capture, record pop, levels and sticky status.
interface audio_sample_fifo_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] play_data;
   logic             play_valid;
   logic             play_ready;
   logic             dacdat_req;
   logic [WIDTH-1:0] dacdat_in;
   logic [WIDTH-1:0] adcdat_out;
   logic             adcdat_vld;
   logic [WIDTH-1:0] rec_data;
   logic             rec_valid;
   logic             rec_ready;
   logic [AW:0]      play_level;
   logic [AW:0]      rec_level;
   logic             play_underrun;
   logic             rec_overflow;
   logic             clr_status;

   modport slave (
      input  play_data, play_valid, dacdat_req, adcdat_out, adcdat_vld,
             rec_ready, clr_status,
      output play_ready, dacdat_in, rec_data, rec_valid, play_level,
             rec_level, play_underrun, rec_overflow
   );

   modport master (
      output play_data, play_valid, dacdat_req, adcdat_out, adcdat_vld,
             rec_ready, clr_status,
      input  play_ready, dacdat_in, rec_data, rec_valid, play_level,
             rec_level, play_underrun, rec_overflow
   );
endinterface

// File: rtl/audio_sample_fifo.sv
// Dual audio sample FIFO: a playback FIFO feeding the DAC on request and a
// first-word-fall-through record FIFO collecting ADC samples for the host.
module audio_sample_fifo #(
   parameter int WIDTH         = 32,
   parameter int DEPTH         = 16,
   parameter int UNDERRUN_HOLD = 0
) (
   input logic                clk,
   input logic                rst,
   audio_sample_fifo_if.slave bus
);
   localparam int          AW         = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

   // ---------------- playback path ----------------
   logic [WIDTH-1:0] play_mem [DEPTH];
   logic [AW:0]      play_wr_ptr_reg, play_wr_ptr_next;
   logic [AW:0]      play_rd_ptr_reg, play_rd_ptr_next;
   logic [AW:0]      play_level_reg, play_level_next;
   logic             play_ready_reg;
   logic             play_underrun_reg, play_underrun_next;
   logic [WIDTH-1:0] dacdat_reg;
   logic [WIDTH-1:0] underrun_fill;
   logic             play_push, play_pop, play_empty_req;
   logic [AW-1:0]    play_wr_addr, play_rd_addr;

   always_comb begin
      play_push          = bus.play_valid && play_ready_reg;
      play_pop           = bus.dacdat_req && (play_level_reg != '0);
      play_empty_req     = bus.dacdat_req && (play_level_reg == '0);
      play_wr_addr       = play_wr_ptr_reg[AW-1:0];
      play_rd_addr       = play_rd_ptr_reg[AW-1:0];
      play_wr_ptr_next   = play_wr_ptr_reg + (AW + 1)'(play_push);
      play_rd_ptr_next   = play_rd_ptr_reg + (AW + 1)'(play_pop);
      play_level_next    = play_wr_ptr_next - play_rd_ptr_next;
      play_underrun_next = play_empty_req || (play_underrun_reg && !bus.clr_status);
   end

   // Sample presented to the DAC when a request finds the FIFO empty.
   generate
      if (UNDERRUN_HOLD != 0) begin : g_underrun_hold
         assign underrun_fill = dacdat_reg;
      end else begin : g_underrun_zero
         assign underrun_fill = '0;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         play_wr_ptr_reg   <= '0;
         play_rd_ptr_reg   <= '0;
         play_level_reg    <= '0;
         play_ready_reg    <= 1'b1;
         play_underrun_reg <= 1'b0;
      end else begin
         play_wr_ptr_reg   <= play_wr_ptr_next;
         play_rd_ptr_reg   <= play_rd_ptr_next;
         play_level_reg    <= play_level_next;
         play_ready_reg    <= (play_level_next != FULL_LEVEL);
         play_underrun_reg <= play_underrun_next;
      end
   end

   always_ff @(posedge clk) begin
      if (play_push && !rst) begin
         play_mem[play_wr_addr] <= bus.play_data;
      end
   end

   // Registered read port doubles as the DAC output holding register.
   always_ff @(posedge clk) begin
      if (rst) begin
         dacdat_reg <= '0;
      end else if (play_pop) begin
         dacdat_reg <= play_mem[play_rd_addr];
      end else if (play_empty_req) begin
         dacdat_reg <= underrun_fill;
      end
   end

   // ---------------- record path ----------------
   logic [WIDTH-1:0] rec_mem [DEPTH];
   logic [AW:0]      rec_wr_ptr_reg, rec_wr_ptr_next;
   logic [AW:0]      rec_rd_ptr_reg, rec_rd_ptr_next;
   logic [AW:0]      rec_level_reg, rec_level_next;
   logic             rec_valid_reg;
   logic             rec_overflow_reg, rec_overflow_next;
   logic [WIDTH-1:0] rec_head_reg;
   logic             rec_push, rec_pop, rec_drop, rec_bypass;
   logic [AW-1:0]    rec_wr_addr, rec_rd_addr_next;

   always_comb begin
      rec_pop           = rec_valid_reg && bus.rec_ready;
      rec_push          = bus.adcdat_vld && ((rec_level_reg != FULL_LEVEL) || rec_pop);
      rec_drop          = bus.adcdat_vld && !rec_push;
      rec_wr_addr       = rec_wr_ptr_reg[AW-1:0];
      rec_wr_ptr_next   = rec_wr_ptr_reg + (AW + 1)'(rec_push);
      rec_rd_ptr_next   = rec_rd_ptr_reg + (AW + 1)'(rec_pop);
      rec_rd_addr_next  = rec_rd_ptr_next[AW-1:0];
      rec_level_next    = rec_wr_ptr_next - rec_rd_ptr_next;
      // The new head is being written this very edge, so it is not yet in RAM.
      rec_bypass        = rec_push && (rec_wr_addr == rec_rd_addr_next);
      rec_overflow_next = rec_drop || (rec_overflow_reg && !bus.clr_status);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rec_wr_ptr_reg   <= '0;
         rec_rd_ptr_reg   <= '0;
         rec_level_reg    <= '0;
         rec_valid_reg    <= 1'b0;
         rec_overflow_reg <= 1'b0;
      end else begin
         rec_wr_ptr_reg   <= rec_wr_ptr_next;
         rec_rd_ptr_reg   <= rec_rd_ptr_next;
         rec_level_reg    <= rec_level_next;
         rec_valid_reg    <= (rec_level_next != '0);
         rec_overflow_reg <= rec_overflow_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rec_push && !rst) begin
         rec_mem[rec_wr_addr] <= bus.adcdat_out;
      end
   end

   // Look-ahead read of the next head keeps rec_data fall-through with a
   // registered RAM read port.
   always_ff @(posedge clk) begin
      if (rec_bypass) begin
         rec_head_reg <= bus.adcdat_out;
      end else begin
         rec_head_reg <= rec_mem[rec_rd_addr_next];
      end
   end

   // ---------------- outputs ----------------
   assign bus.play_ready    = play_ready_reg;
   assign bus.dacdat_in     = dacdat_reg;
   assign bus.play_level    = play_level_reg;
   assign bus.play_underrun = play_underrun_reg;
   assign bus.rec_data      = rec_head_reg;
   assign bus.rec_valid     = rec_valid_reg;
   assign bus.rec_level     = rec_level_reg;
   assign bus.rec_overflow  = rec_overflow_reg;
endmodule

// File: tb/tb_audio_sample_fifo.sv
// Scoreboard bench for audio_sample_fifo: the driver models both FIFOs and
// queues expected samples, a monitor compares them as the DUT presents them.
module tb_audio_sample_fifo;
   localparam int DEPTH  = 8;
   localparam int DEPTH1 = 4;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   audio_sample_fifo_if #(.WIDTH(32), .DEPTH(DEPTH))  bus  ();
   audio_sample_fifo_if #(.WIDTH(32), .DEPTH(DEPTH1)) bus1 ();

   audio_sample_fifo #(.WIDTH(32), .DEPTH(DEPTH), .UNDERRUN_HOLD(0)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   audio_sample_fifo #(.WIDTH(32), .DEPTH(DEPTH1), .UNDERRUN_HOLD(1)) u_dut_hold (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // model state
   logic [31:0] m_play[$];
   logic [31:0] exp_dac[$];
   logic [31:0] exp_rec[$];
   int          rec_cnt;
   bit          m_under;
   bit          m_over;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // ---------------- monitor ----------------
   logic        dac_due;
   logic [31:0] mon_exp;

   always @(posedge clk) dac_due <= bus.dacdat_req && !rst;

   always @(negedge clk) begin
      if (dac_due) begin
         n_checks++;
         if (exp_dac.size() == 0) begin
            n_errors++;
            $display("FAIL dac_sample: got %h required no request pending", bus.dacdat_in);
         end else begin
            mon_exp = exp_dac.pop_front();
            if (bus.dacdat_in !== mon_exp) begin
               n_errors++;
               $display("FAIL dac_sample: got %h required %h", bus.dacdat_in, mon_exp);
            end else begin
               $display("dac  sample %h", bus.dacdat_in);
            end
         end
      end
      if (!rst && bus.rec_valid && bus.rec_ready) begin
         n_checks++;
         if (exp_rec.size() == 0) begin
            n_errors++;
            $display("FAIL rec_sample: got %h required no sample buffered", bus.rec_data);
         end else begin
            mon_exp = exp_rec.pop_front();
            if (bus.rec_data !== mon_exp) begin
               n_errors++;
               $display("FAIL rec_sample: got %h required %h", bus.rec_data, mon_exp);
            end else begin
               $display("rec  sample %h", bus.rec_data);
            end
         end
      end
   end

   // ---------------- driver ----------------
   // One cycle: check pre-edge state against the model, drive, update model.
   task automatic step(input logic pv, input logic [31:0] pd, input logic req,
                       input logic vld, input logic [31:0] adc, input logic rr,
                       input logic clr);
      int          psz;
      bit          p_ready, p_pop, r_pop, r_push;
      logic [31:0] tmp;
      psz     = m_play.size();
      p_ready = (psz != DEPTH);
      check("play_level",    32'(bus.play_level),    32'(psz));
      check("play_ready",    32'(bus.play_ready),    32'(p_ready));
      check("rec_level",     32'(bus.rec_level),     32'(rec_cnt));
      check("rec_valid",     32'(bus.rec_valid),     32'(rec_cnt != 0));
      check("play_underrun", 32'(bus.play_underrun), 32'(m_under));
      check("rec_overflow",  32'(bus.rec_overflow),  32'(m_over));

      bus.play_valid = pv;
      bus.play_data  = pd;
      bus.dacdat_req = req;
      bus.adcdat_vld = vld;
      bus.adcdat_out = adc;
      bus.rec_ready  = rr;
      bus.clr_status = clr;

      p_pop = req && (psz != 0);
      if (req) begin
         if (p_pop) begin
            tmp = m_play.pop_front();
            exp_dac.push_back(tmp);
         end else begin
            exp_dac.push_back(32'h0);
         end
      end
      if (pv && p_ready) m_play.push_back(pd);
      m_under = (req && psz == 0) || (m_under && !clr);

      r_pop  = rr && (rec_cnt != 0);
      r_push = vld && ((rec_cnt != DEPTH) || r_pop);
      if (r_push) exp_rec.push_back(adc);
      rec_cnt = rec_cnt + (r_push ? 1 : 0) - (r_pop ? 1 : 0);
      m_over  = (vld && !r_push) || (m_over && !clr);

      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic do_reset(input logic busy);
      bus.play_valid = busy;
      bus.play_data  = 32'hBADC0DE0;
      bus.dacdat_req = busy;
      bus.adcdat_vld = busy;
      bus.adcdat_out = 32'hBADC0DE1;
      bus.rec_ready  = 1'b0;
      bus.clr_status = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.play_valid = 1'b0;
      bus.dacdat_req = 1'b0;
      bus.adcdat_vld = 1'b0;
      m_play.delete();
      exp_dac.delete();
      exp_rec.delete();
      rec_cnt = 0;
      m_under = 1'b0;
      m_over  = 1'b0;
      check("dacdat_after_rst", bus.dacdat_in, 32'h0);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rec_cnt  = 0;
      m_under  = 1'b0;
      m_over   = 1'b0;
      rst      = 1'b1;
      bus.play_valid = 1'b0; bus.play_data = '0; bus.dacdat_req = 1'b0;
      bus.adcdat_vld = 1'b0; bus.adcdat_out = '0; bus.rec_ready = 1'b0;
      bus.clr_status = 1'b0;
      bus1.play_valid = 1'b0; bus1.play_data = '0; bus1.dacdat_req = 1'b0;
      bus1.adcdat_vld = 1'b0; bus1.adcdat_out = '0; bus1.rec_ready = 1'b0;
      bus1.clr_status = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("dacdat_reset", bus.dacdat_in, 32'h0);
      idle();

      // two pushes then two requests
      step(1'b1, 32'h11112222, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b1, 32'h33334444, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      idle();

      // fill to DEPTH, rejected push, pop reopens ready, push+pop, drain
      for (int i = 0; i < DEPTH; i++) step(1'b1, 32'hA0000000 + i, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b1, 32'hBAD0BAD0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b1, 32'hBAD1BAD1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      idle();
      for (int i = 0; i < 3; i++) step(1'b1, 32'hC0000000 + i, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      repeat (DEPTH + 2) step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

      // underrun, clear, clear racing a new underrun, push into empty with req
      step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      step(1'b1, 32'h5555AAAA, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      idle();

      // record overflow, then pop+vld at full, then drain
      for (int i = 0; i <= DEPTH; i++) step(1'b0, 32'h0, 1'b0, 1'b1, 32'hD0000000 + i, 1'b0, 1'b0);
      idle();
      step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      step(1'b0, 32'h0, 1'b0, 1'b1, 32'hE0000000, 1'b1, 1'b0);
      idle();
      repeat (DEPTH + 2) step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

      // mid-operation reset with samples in both FIFOs and a flag set
      step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 32'hF0000000 + i, 1'b0, 1'b1, 32'hF1000000 + i, 1'b0, 1'b0);
      step(1'b1, 32'hF0000003, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      do_reset(1'b1);
      idle();
      step(1'b1, 32'h12345678, 1'b0, 1'b1, 32'h87654321, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      idle();

      // random traffic on both paths
      for (int i = 0; i < 3000; i++) begin
         step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 15) == 0));
      end
      repeat (DEPTH + 2) step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      idle();
      @(negedge clk);
      #1;
      check("dac_queue_left", 32'(exp_dac.size()), 32'h0);
      check("rec_queue_left", 32'(exp_rec.size()), 32'h0);

      // hold-on-underrun instance
      @(posedge clk);
      #1;
      bus1.play_valid = 1'b1;
      bus1.play_data  = 32'hDEADBEEF;
      @(posedge clk);
      #1;
      bus1.play_valid = 1'b0;
      bus1.dacdat_req = 1'b1;
      @(posedge clk);
      #1;
      bus1.dacdat_req = 1'b0;
      check("hold_dac_pop", bus1.dacdat_in, 32'hDEADBEEF);
      check("hold_level", 32'(bus1.play_level), 32'h0);
      bus1.dacdat_req = 1'b1;
      @(posedge clk);
      #1;
      bus1.dacdat_req = 1'b0;
      check("hold_dac_underrun", bus1.dacdat_in, 32'hDEADBEEF);
      check("hold_underrun_flag", 32'(bus1.play_underrun), 32'h1);
      bus1.clr_status = 1'b1;
      @(posedge clk);
      #1;
      bus1.clr_status = 1'b0;
      check("hold_underrun_clr", 32'(bus1.play_underrun), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
